// File: rtl/bb_pkg.sv
// Shared types and helpers for the baseball game sequencer.
// Contents: action code enum, sequencer state enum, game-length constants and
// per-action helpers for out counting and the single-bit base model.
package bb_pkg;

  typedef enum logic [2:0] {
    ActBb,
    ActH1,
    ActH2,
    ActH3,
    ActHr,
    ActBunt,
    ActGround,
    ActFly
  } act_e;

  typedef enum logic {
    StIdle,
    StPlay
  } state_e;

  localparam int unsigned OUTS_PER_HALF = 3;
  localparam int unsigned LAST_INNING   = 3;

  // Outs added by one action; a ground ball with a runner on first is a double play.
  function automatic logic [1:0] outs_for(logic [2:0] act, logic first_occ);
    logic [1:0] outs;
    outs = 2'd0;
    case (act)
      ActBunt, ActFly: outs = 2'd1;
      ActGround:       outs = first_occ ? 2'd2 : 2'd1;
      default:         outs = 2'd0;
    endcase
    return outs;
  endfunction

  // Runner-on-first after one action; a fly ball leaves the runner in place.
  function automatic logic first_occ_next(logic [2:0] act, logic first_occ);
    logic occ;
    occ = 1'b0;
    case (act)
      ActBb, ActH1: occ = 1'b1;
      ActFly:       occ = first_occ;
      default:      occ = 1'b0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/bb_act_fifo.sv
// Synchronous action FIFO placed in front of the sequencer.
// Ports: clk/rst_n (async active-low), i_push/i_data write side, i_pop read side,
// o_data head entry (valid when !o_empty), o_full/o_empty flags.
// Push while full and pop while empty are ignored.
module bb_act_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [2:0] i_data,
  input  logic       i_pop,
  output logic [2:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [2:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_push;
  logic        w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bb_game_sched.sv
// Game sequencer: turns host action codes into a contiguous scorer beat stream,
// tracking outs, a runner-on-first bit and inning/half, and ending the game after
// the bottom of the last inning.
// Ports: clk, rst_n (async active-low); start; act_valid/act_data/act_ready host
// handshake; in_valid/inning/half/action scorer beat; busy (PLAY); game_done and
// underrun one-cycle pulses.
// Option: define BB_SCHED_FIFO_EN to place a FIFO_DEPTH-entry action FIFO in front
// of the sequencer (host may preload while idle). Default build is pass-through.
module bb_game_sched
  import bb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       act_valid,
  input  logic [2:0] act_data,
  output logic       act_ready,
  output logic       in_valid,
  output logic [1:0] inning,
  output logic       half,
  output logic [2:0] action,
  output logic       busy,
  output logic       game_done,
  output logic       underrun
);

  localparam logic [2:0] OutsEnd = 3'(OUTS_PER_HALF);
  localparam logic [1:0] LastInn = 2'(LAST_INNING);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  state_e     r_state;
  logic       r_busy;
  logic       r_over;      // final out issued; leave PLAY on the next edge
  logic [1:0] r_outs;
  logic       r_first_occ;
  logic [1:0] r_inning;
  logic       r_half;
  logic       r_in_valid;
  logic [1:0] r_out_inning;
  logic       r_out_half;
  logic [2:0] r_out_action;
  logic       r_game_done;
  logic       r_underrun;

  logic       w_avail;
  logic [2:0] w_act;
  logic [2:0] w_outs_sum;
  logic       w_half_end;
  logic       w_game_end;

`ifdef BB_SCHED_FIFO_EN
  logic w_full;
  logic w_empty;
  logic w_pop;

  assign w_pop = (r_state == StPlay) && !r_over && !w_empty;

  bb_act_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (act_valid),
    .i_data  (act_data),
    .i_pop   (w_pop),
    .o_data  (w_act),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign act_ready = !w_full;
  assign w_avail   = !w_empty;
`else
  // Hold off the host during the cycle that shows the final beat.
  assign act_ready = r_busy && !r_over;
  assign w_avail   = act_valid;
  assign w_act     = act_data;
`endif

  assign w_outs_sum = {1'b0, r_outs} + {1'b0, outs_for(w_act, r_first_occ)};
  assign w_half_end = (w_outs_sum >= OutsEnd);
  assign w_game_end = w_half_end && r_half && (r_inning == LastInn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_busy       <= 1'b0;
      r_over       <= 1'b0;
      r_outs       <= 2'd0;
      r_first_occ  <= 1'b0;
      r_inning     <= 2'd0;
      r_half       <= 1'b0;
      r_in_valid   <= 1'b0;
      r_out_inning <= 2'd0;
      r_out_half   <= 1'b0;
      r_out_action <= 3'd0;
      r_game_done  <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_game_done <= 1'b0;
      r_underrun  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StPlay;
            r_busy      <= 1'b1;
            r_over      <= 1'b0;
            r_outs      <= 2'd0;
            r_first_occ <= 1'b0;
            r_inning    <= 2'd1;
            r_half      <= 1'b0;
          end
        end
        StPlay: begin
          if (r_over || !w_avail) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_over       <= 1'b0;
            r_in_valid   <= 1'b0;
            r_out_inning <= 2'd0;
            r_out_half   <= 1'b0;
            r_out_action <= 3'd0;
            r_game_done  <= r_over;
            r_underrun   <= !r_over;
          end else begin
            // Beat carries the inning/half in force before this action's outs.
            r_in_valid   <= 1'b1;
            r_out_inning <= r_inning;
            r_out_half   <= r_half;
            r_out_action <= w_act;
            if (w_game_end) begin
              r_over <= 1'b1;
              r_outs <= 2'(OUTS_PER_HALF);
            end else if (w_half_end) begin
              r_outs      <= 2'd0;
              r_first_occ <= 1'b0;
              r_half      <= !r_half;
              if (r_half) r_inning <= r_inning + 2'd1;
            end else begin
              r_outs      <= w_outs_sum[1:0];
              r_first_occ <= first_occ_next(w_act, r_first_occ);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_valid  = r_in_valid;
  assign inning    = r_out_inning;
  assign half      = r_out_half;
  assign action    = r_out_action;
  assign busy      = r_busy;
  assign game_done = r_game_done;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_bb_game_sched.sv
module tb_bb_game_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       act_valid;
  logic [2:0] act_data;
  logic       act_ready;
  logic       in_valid;
  logic [1:0] inning;
  logic       half;
  logic [2:0] action;
  logic       busy;
  logic       game_done;
  logic       underrun;

  always #5 clk = ~clk;

  bb_game_sched #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .act_valid (act_valid),
    .act_data  (act_data),
    .act_ready (act_ready),
    .in_valid  (in_valid),
    .inning    (inning),
    .half      (half),
    .action    (action),
    .busy      (busy),
    .game_done (game_done),
    .underrun  (underrun)
  );

  typedef struct {
    logic [2:0] act;
    logic [1:0] inn;
    logic       hf;
  } vec_t;

  typedef struct packed {
    logic [1:0] inn;
    logic       hf;
    logic [2:0] act;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic void add(input int act, input int inn, input int hf);
    vec_t v;
    v.act = 3'(act);
    v.inn = 2'(inn);
    v.hf  = 1'(hf);
    vecs.push_back(v);
  endfunction

  // Scoreboard: every scorer beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && in_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got beat %0d/%0d/%0d expected none at %0t",
                 inning, half, action, $time);
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat", 32'({inning, half, action}), 32'(e));
      end
    end
  end

  function automatic logic [31:0] all_outs();
    return 32'({act_ready, in_valid, inning, half, action, busy, game_done, underrun});
  endfunction

  // Play vecs[first +: n] back-to-back from a fresh start, then expect either
  // a normal completion or an underrun on the cycle after the last beat.
  task automatic run_seq(input string name, input int first, input int n, input bit exp_done);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    for (int i = first; i < first + n; i++) begin
      act_valid = 1'b1;
      act_data  = vecs[i].act;
      sb.push_back({vecs[i].inn, vecs[i].hf, vecs[i].act});
      @(posedge clk);
      #1;
    end
    act_valid = 1'b0;
    act_data  = 3'd0;
    @(negedge clk);
    check({name, "_busy_last_beat"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({name, "_end_flags"}, 32'({in_valid, busy, game_done, underrun}),
          32'({1'b0, 1'b0, exp_done, !exp_done}));
    check({name, "_idle_fields"}, 32'({inning, half, action}), 32'd0);
    check({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    check({name, "_pulse_one_cycle"}, 32'({game_done, underrun}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g_fly, g_mix, g_dp, g_bunt, g_sat, g_under, g_restart, g_rst;

    // Stimulus table with hand-derived (inning, half) per beat.
    g_fly = vecs.size();
    for (int i = 0; i < 18; i++) add(7, i / 6 + 1, (i / 3) % 2);
    g_mix = vecs.size();
    for (int h = 0; h < 6; h++) begin
      if (h % 2 == 0) begin
        add(4, h / 2 + 1, 0); add(1, h / 2 + 1, 0); add(6, h / 2 + 1, 0); add(7, h / 2 + 1, 0);
      end else begin
        add(2, h / 2 + 1, 1); add(3, h / 2 + 1, 1); add(0, h / 2 + 1, 1);
        add(6, h / 2 + 1, 1); add(5, h / 2 + 1, 1);
      end
    end
    g_dp = vecs.size();
    add(0, 1, 0); add(6, 1, 0); add(7, 1, 0); add(7, 1, 1);
    g_bunt = vecs.size();
    add(1, 1, 0); add(5, 1, 0); add(6, 1, 0); add(7, 1, 0); add(0, 1, 1);
    g_sat = vecs.size();
    add(0, 1, 0); add(7, 1, 0); add(7, 1, 0); add(6, 1, 0); add(7, 1, 1);
    g_under = vecs.size();
    for (int i = 0; i < 5; i++) add(7, 1, i / 3);
    g_restart = vecs.size();
    add(0, 1, 0);
    g_rst = vecs.size();
    for (int i = 0; i < 8; i++) add(7, i / 6 + 1, (i / 3) % 2);

    rst_n     = 1'b0;
    start     = 1'b0;
    act_valid = 1'b0;
    act_data  = 3'd0;
    #1 check("reset_outputs", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef BB_SCHED_FIFO_EN
    check("fifo_idle_ready", 32'({act_ready, busy}), 32'({1'b1, 1'b0}));
    // Preload 7,0,6,1 while idle: the ground ball doubles up, closing the top.
    begin
      logic [2:0] pre_act [4];
      logic       pre_hf  [4];
      pre_act[0] = 3'd7; pre_act[1] = 3'd0; pre_act[2] = 3'd6; pre_act[3] = 3'd1;
      pre_hf[0]  = 1'b0; pre_hf[1]  = 1'b0; pre_hf[2]  = 1'b0; pre_hf[3]  = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        check("fifo_ready_preload", 32'(act_ready), 32'd1);
        act_valid = 1'b1;
        act_data  = pre_act[i];
        sb.push_back({2'd1, pre_hf[i], pre_act[i]});
        @(posedge clk);
        #1;
      end
    end
    act_valid = 1'b0;
    check("fifo_full_ready_low", 32'({act_ready, busy, in_valid}), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("fifo_drain_ready", 32'(act_ready), 32'd1);
    @(negedge clk);
    check("fifo_empty_underrun", 32'({in_valid, busy, underrun}), 32'({1'b0, 1'b0, 1'b1}));
    check("fifo_sb_drained", 32'(sb.size()), 32'd0);
`else
    check("idle_not_ready", 32'({act_ready, busy}), 32'd0);
    run_seq("fly_game", g_fly, 18, 1'b1);
    run_seq("mixed_game", g_mix, 27, 1'b1);
    run_seq("double_play", g_dp, 4, 1'b0);
    run_seq("bunt_clears", g_bunt, 5, 1'b0);
    run_seq("sat_outs", g_sat, 5, 1'b0);
    run_seq("drop_valid", g_under, 5, 1'b0);
    run_seq("restart", g_restart, 1, 1'b0);

    // Reset in the middle of the 2nd inning.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = g_rst; i < g_rst + 8; i++) begin
      act_valid = 1'b1;
      act_data  = vecs[i].act;
      sb.push_back({vecs[i].inn, vecs[i].hf, vecs[i].act});
      @(posedge clk);
      #1;
    end
    act_valid = 1'b0;
    @(negedge clk);
    check("mid_game_ready", 32'({act_ready, busy}), 32'({1'b1, 1'b1}));
    #1 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 32'd0);
    act_valid = 1'b1;
    act_data  = 3'd4;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", all_outs(), 32'd0);
    act_valid = 1'b0;
    check("reset_sb_drained", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
